regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised 2-read/2-write CPU register file with write-to-read bypass and a per-register busy scoreboard.
//  Sits between decode (read ports, busy check, issue marking) and writeback (two retire ports) of the pipelined core.
//  Register 0 reads as zero, is never written and is never busy.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   address width; NREGS = 2**ADDR_W
//  FORWARD  1   1: same-cycle write data bypasses to read ports; 0: write visible from next cycle
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high; clears all registers and busy bits
//  ra1, ra2   in   ADDR_W  read addresses
//  rd1, rd2   out  DATA_W  read data (combinational from ra*, state and bypass)
//  rb1, rb2   out  1       busy flag of ra1 / ra2 (combinational)
//  we0, we1   in   1       write enables, writeback ports 0 and 1
//  wa0, wa1   in   ADDR_W  write addresses
//  wd0, wd1   in   DATA_W  write data
//  iss        in   1       issue strobe: mark register isa busy
//  isa        in   ADDR_W  register being claimed by issued instruction
//  nbusy      out  ADDR_W+1 count of busy registers (registered)
// BEHAVIOUR
//  - Reset: all NREGS registers = 0, all busy bits = 0, nbusy = 0; reset dominates every other input that cycle.
//  - Write: on clk edge, we_k && wa_k != 0 -> reg[wa_k] <= wd_k; we to address 0 ignored.
//  - Same-address dual write (we0 && we1 && wa0 == wa1): port 1 wins; port 0 data discarded.
//  - Read: rd_n = 0 when ra_n == 0; else FORWARD=1 and matching write this cycle -> that wd (port 1 over port 0);
//    otherwise stored reg[ra_n]. FORWARD=0 -> stored value only (old value in write cycle).
//  - Scoreboard: busy[a] set on iss && isa == a != 0; cleared on we_k && wa_k == a.
//    Simultaneous set and clear of same address: set wins (new producer supersedes retiring one).
//    iss to address 0 ignored; busy[0] constant 0.
//  - rb_n = busy[ra_n], except FORWARD=1 and a write to ra_n this cycle (and no iss to it) -> rb_n = 0.
//  - nbusy updated every cycle to popcount of next busy vector; never exceeds NREGS-1.
//  - Write to non-busy register is legal (data written, busy stays 0); no error flag.
//  - Reset mid-operation: pending busy bits and in-flight writes that cycle are lost; outputs read 0 next cycle.
// STRUCTURE
//  - Shared package cpu_pkg: DATA_W/ADDR_W defaults, REG_ZERO constant, reg address typedef.
//  - One sub-module: regfile_scoreboard (busy vector, set/clear priority, nbusy popcount).
//  - Top holds storage array, write arbitration, bypass muxes.
// TESTING
//  1 reset asserted 2 cycles after random writes -> all rd = 0, rb = 0, nbusy = 0 next cycle.
//  2 we0 wa0=5 wd0=0xDEADBEEF, ra1=5 same cycle -> FORWARD=1: rd1=0xDEADBEEF same cycle; FORWARD=0: old value, then 0xDEADBEEF.
//  3 we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 -> reg7 = 0x22; bypass also shows 0x22.
//  4 we0 wa0=0 wd0=0xFFFFFFFF, iss isa=0 -> rd(ra=0) = 0, rb = 0, nbusy unchanged.
//  5 iss isa=3; next cycle rb(ra=3)=1, nbusy=1; then iss isa=3 and we1 wa1=3 together -> busy stays 1, nbusy=1.
//  6 iss on regs 1..31 over 31 cycles -> nbusy=31; retire all via both ports -> nbusy=0, all rb=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: default datapath widths and the hard-wired zero register.
package cpu_pkg;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef logic [CPU_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination busy, writeback retires it.
// A same-cycle issue to a retiring register keeps it busy because the newer producer owns it.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int FORWARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss,
    input  logic [ADDR_W-1:0] isa,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              rb1,
    output logic              rb2,
    output logic [ADDR_W:0]   nbusy
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [ADDR_W:0]  busy_cnt;

    always_comb begin
        busy_next = busy;
        busy_cnt  = '0;
        for (int i = 1; i < NREGS; i++) begin
            if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i)))
                busy_next[i] = 1'b0;
            if (iss && isa == ADDR_W'(i))
                busy_next[i] = 1'b1;
            busy_cnt = busy_cnt + (ADDR_W + 1)'(busy_next[i]);
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= '0;
            nbusy <= '0;
        end else begin
            busy  <= busy_next;
            nbusy <= busy_cnt;
        end
    end

    // With bypass enabled, a retiring register is already free to the reader unless re-claimed now.
    logic hit1, hit2;
    assign hit1 = (we0 && wa0 == ra1) || (we1 && wa1 == ra1);
    assign hit2 = (we0 && wa0 == ra2) || (we1 && wa1 == ra2);

    assign rb1 = (FORWARD != 0 && hit1 && !(iss && isa == ra1)) ? 1'b0 : busy[ra1];
    assign rb2 = (FORWARD != 0 && hit2 && !(iss && isa == ra2)) ? 1'b0 : busy[ra2];
endmodule

// File: rtl/regfile_sb.sv
// 2-read/2-write register file with optional write-to-read bypass and a busy scoreboard.
// Register 0 is hard-wired to zero; port 1 wins a same-address dual write.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int FORWARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rb1,
    output logic              rb2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss,
    input  logic [ADDR_W-1:0] isa,
    output logic [ADDR_W:0]   nbusy
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              w0_en, w1_en;

    assign w0_en = we0 && wa0 != ADDR_W'(REG_ZERO);
    assign w1_en = we1 && wa1 != ADDR_W'(REG_ZERO);

    // Port 1 is assigned last so it overrides port 0 on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (w0_en) regs[wa0] <= wd0;
            if (w1_en) regs[wa1] <= wd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              e0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              e1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1
    );
        if (ra == ADDR_W'(REG_ZERO)) return '0;
        if (FORWARD != 0 && e1 && a1 == ra) return d1;
        if (FORWARD != 0 && e0 && a0 == ra) return d0;
        return stored;
    endfunction

    assign rd1 = read_port(ra1, regs[ra1], w0_en, wa0, wd0, w1_en, wa1, wd1);
    assign rd2 = read_port(ra2, regs[ra2], w0_en, wa0, wd0, w1_en, wa1, wd1);

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .FORWARD (FORWARD)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .iss   (iss),
        .isa   (isa),
        .we0   (we0),
        .wa0   (wa0),
        .we1   (we1),
        .wa1   (wa1),
        .ra1   (ra1),
        .ra2   (ra2),
        .rb1   (rb1),
        .rb2   (rb2),
        .nbusy (nbusy)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share all inputs.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra1, ra2, wa0, wa1, isa;
    logic [31:0] wd0, wd1;
    logic        we0, we1, iss;

    logic [31:0] rd1_f, rd2_f, rd1_n, rd2_n;
    logic        rb1_f, rb2_f, rb1_n, rb2_n;
    logic [5:0]  nbusy_f, nbusy_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .FORWARD(1)) dut_f (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_f), .rd2(rd2_f),
        .rb1(rb1_f), .rb2(rb2_f), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
        .wa1(wa1), .wd1(wd1), .iss(iss), .isa(isa), .nbusy(nbusy_f)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .FORWARD(0)) dut_n (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .rb1(rb1_n), .rb2(rb2_n), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
        .wa1(wa1), .wd1(wd1), .iss(iss), .isa(isa), .nbusy(nbusy_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
        wa0 = '0; wa1 = '0; isa = '0; wd0 = '0; wd1 = '0;
    endtask

    initial begin
        idle();
        ra1 = '0; ra2 = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Power-up reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        ra1 = 5'd5; ra2 = 5'd9;
        #1;
        chk("rst_rd1", rd1_f, 0);
        chk("rst_rb1", rb1_f, 0);
        chk("rst_nbusy_f", nbusy_f, 0);
        chk("rst_nbusy_n", nbusy_n, 0);

        // 1: random writes to 10..20 plus one claim of r9, then reset with traffic
        iss = 1'b1; isa = 5'd9;
        for (int c = 0; c < 4; c++) begin
            we0 = 1'b1; wa0 = 5'($urandom_range(10, 20)); wd0 = $urandom;
            we1 = 1'b1; wa1 = 5'($urandom_range(10, 20)); wd1 = $urandom;
            tick();
            model[wa0] = wd0;
            model[wa1] = wd1;
            iss = 1'b0;
        end
        idle();
        for (int a = 10; a <= 20; a++) exp_q.push_back(model[a]);
        for (int a = 10; a <= 20; a++) begin
            ra1 = 5'(a);
            #1;
            chk("rand_rd_f", rd1_f, exp_q[0]);
            chk("rand_rd_n", rd1_n, exp_q.pop_front());
        end
        chk("rand_nbusy", nbusy_f, 1);
        ra2 = 5'd9; #1;
        chk("rand_rb2_r9", rb2_f, 1);
        tick();
        reset = 1'b1;
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hCAFE_0001; iss = 1'b1; isa = 5'd12;
        tick();
        reset = 1'b0;
        idle();
        for (int a = 9; a <= 20; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            #1;
            chk("post_rst_rd1", rd1_f, 0);
            chk("post_rst_rd2_n", rd2_n, 0);
            chk("post_rst_rb1", rb1_f, 0);
        end
        chk("post_rst_nbusy_f", nbusy_f, 0);
        chk("post_rst_nbusy_n", nbusy_n, 0);

        // 2: bypass vs. no bypass on a write to r5 holding an older value
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_1234;
        tick();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra1 = 5'd5;
        #1;
        chk("fwd_rd1_same_cycle", rd1_f, 32'hDEAD_BEEF);
        chk("nofwd_rd1_old", rd1_n, 32'h0000_1234);
        tick();
        idle();
        #1;
        chk("fwd_rd1_next", rd1_f, 32'hDEAD_BEEF);
        chk("nofwd_rd1_next", rd1_n, 32'hDEAD_BEEF);

        // 3: same-address dual write, port 1 wins in storage and bypass
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        ra2 = 5'd7;
        #1;
        chk("dual_fwd_rd2", rd2_f, 32'h22);
        chk("dual_nofwd_rd2_old", rd2_n, 32'h0);
        tick();
        idle();
        #1;
        chk("dual_rd2_f", rd2_f, 32'h22);
        chk("dual_rd2_n", rd2_n, 32'h22);

        // 4: writes and issues to r0 are ignored
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; iss = 1'b1; isa = 5'd0; ra1 = 5'd0;
        #1;
        chk("r0_rd1_f", rd1_f, 0);
        chk("r0_rd1_n", rd1_n, 0);
        chk("r0_rb1", rb1_f, 0);
        tick();
        idle();
        #1;
        chk("r0_rd1_after", rd1_f, 0);
        chk("r0_rb1_after", rb1_n, 0);
        chk("r0_nbusy", nbusy_f, 0);

        // 5: claim r3, then a simultaneous re-claim and retire keeps it busy
        iss = 1'b1; isa = 5'd3; ra1 = 5'd3;
        #1;
        chk("claim_rb1_before", rb1_f, 0);
        tick();
        idle();
        #1;
        chk("claim_rb1", rb1_f, 1);
        chk("claim_nbusy", nbusy_f, 1);
        iss = 1'b1; isa = 5'd3; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h33;
        #1;
        chk("setclr_rb1_f", rb1_f, 1);
        chk("setclr_rb1_n", rb1_n, 1);
        chk("setclr_rd1_f", rd1_f, 32'h33);
        tick();
        idle();
        #1;
        chk("setclr_rb1_after", rb1_f, 1);
        chk("setclr_nbusy", nbusy_f, 1);
        chk("setclr_rd1_n", rd1_n, 32'h33);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h44;
        #1;
        chk("retire_rb1_fwd", rb1_f, 0);
        chk("retire_rb1_nofwd", rb1_n, 1);
        tick();
        idle();
        #1;
        chk("retire_rb1_after", rb1_n, 0);
        chk("retire_nbusy", nbusy_n, 0);

        // 6: claim every register, then retire two per cycle
        for (int a = 1; a <= 31; a++) begin
            iss = 1'b1; isa = 5'(a);
            tick();
            chk("fill_nbusy", nbusy_f, 64'(a));
        end
        idle();
        chk("full_nbusy_n", nbusy_n, 31);
        ra1 = 5'd31; ra2 = 5'd1;
        #1;
        chk("full_rb1", rb1_f, 1);
        chk("full_rb2", rb2_n, 1);
        for (int a = 1; a <= 31; a += 2) begin
            we0 = 1'b1; wa0 = 5'(a); wd0 = 32'(a);
            if (a + 1 <= 31) begin
                we1 = 1'b1; wa1 = 5'(a + 1); wd1 = 32'(a + 1);
            end else begin
                we1 = 1'b0; wa1 = '0;
            end
            tick();
            chk("drain_nbusy", nbusy_f, 64'(31 - ((a + 1 <= 31) ? a + 1 : 31)));
        end
        idle();
        chk("empty_nbusy_f", nbusy_f, 0);
        chk("empty_nbusy_n", nbusy_n, 0);
        for (int a = 1; a <= 31; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            #1;
            chk("empty_rb1", rb1_f, 0);
            chk("empty_rb2_n", rb2_n, 0);
        end
        ra1 = 5'd20; #1;
        chk("drain_rd1_r20", rd1_f, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
